// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Micro-sequencer that runs one complete register-transfer ALU operation on
// data_path for each accepted command. It drives the one-hot register strobes,
// the MDR/Y/Z/HI/LO strobes, Read, Mdatain and op, so a command source only
// has to present a command and pulse start.
//
// Ports
//   Clock        single clock, all state changes on the rising edge
//   clear        asynchronous active-low reset
//   start        command strobe, sampled in IDLE or DONE only
//   cmd_op       ALU opcode
//   cmd_src_a    first operand register (also the preload target)
//   cmd_src_b    second operand register (binary commands only)
//   cmd_dst      destination register (non-wide commands only)
//   cmd_imm_en   preload cmd_imm into cmd_src_a through the MDR first
//   cmd_unary    single operand from cmd_src_a, Y is not loaded
//   cmd_wide     write Zlow->LO and Zhigh->HI instead of cmd_dst
//   cmd_imm      immediate value
//   Read, MDRin, MDRout, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin
//                datapath strobes, each high for exactly one cycle
//   Rin, Rout    one-hot register strobes
//   op           ALU opcode to the datapath (0 in IDLE)
//   Mdatain      memory-data input to the datapath (0 outside MDR_LOAD)
//   busy         high in every state except IDLE and DONE
//   done         one-cycle pulse in DONE
//   err          one-cycle pulse after a command is rejected
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int OP_W     = 5,
  parameter int DATA_W   = 32
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [IDX_W-1:0]    cmd_src_a,
  input  logic [IDX_W-1:0]    cmd_src_b,
  input  logic [IDX_W-1:0]    cmd_dst,
  input  logic                cmd_imm_en,
  input  logic                cmd_unary,
  input  logic                cmd_wide,
  input  logic [DATA_W-1:0]   cmd_imm,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                Yin,
  output logic                Zlowin,
  output logic                Zhighin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OP_W-1:0]     op,
  output logic [DATA_W-1:0]   Mdatain,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MDR_LOAD,
    S_REG_LOAD,
    S_Y_LOAD,
    S_ALU,
    S_ZLO_WB,
    S_ZHI_WB,
    S_DONE
  } state_t;

  state_t              state_q, state_d;

  // Latched command; only the fields needed after acceptance are kept.
  logic [OP_W-1:0]     op_q;
  logic [IDX_W-1:0]    src_a_q, src_b_q, dst_q;
  logic                unary_q, wide_q;
  logic [DATA_W-1:0]   imm_q;
  logic                err_q;

  logic                can_accept, cmd_valid, accept, reject;
  state_t              entry_state;

  // Index range check done at 32 bits so it stays meaningful (and warning
  // free) when NUM_REGS == 2**IDX_W and every index is in range.
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      v[i] = (32'(idx) == 32'(i));
    end
    return v;
  endfunction

  // A command only checks the indices it will actually use.
  always_comb begin
    can_accept  = (state_q == S_IDLE) || (state_q == S_DONE);
    cmd_valid   = idx_ok(cmd_src_a)
                  && (cmd_unary || idx_ok(cmd_src_b))
                  && (cmd_wide  || idx_ok(cmd_dst));
    accept      = can_accept && start && cmd_valid;
    reject      = can_accept && start && !cmd_valid;
    entry_state = cmd_imm_en ? S_MDR_LOAD : (cmd_unary ? S_ALU : S_Y_LOAD);
  end

  // NOTE: every register here is written with <= so all of them update
  // together from the values seen before the edge; blocking = would let
  // later lines see half-updated state.
  // NOTE: the latched command is reset too, not just the state, so nothing
  // downstream ever observes X after clear even though outputs are gated.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      unary_q <= 1'b0;
      wide_q  <= 1'b0;
      imm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= reject;
      if (accept) begin
        op_q    <= cmd_op;
        src_a_q <= cmd_src_a;
        src_b_q <= cmd_src_b;
        dst_q   <= cmd_dst;
        unary_q <= cmd_unary;
        wide_q  <= cmd_wide;
        imm_q   <= cmd_imm;
      end
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = accept ? entry_state : S_IDLE;
      S_MDR_LOAD: state_d = S_REG_LOAD;
      S_REG_LOAD: state_d = unary_q ? S_ALU : S_Y_LOAD;
      S_Y_LOAD:   state_d = S_ALU;
      S_ALU:      state_d = S_ZLO_WB;
      S_ZLO_WB:   state_d = wide_q ? S_ZHI_WB : S_DONE;
      S_ZHI_WB:   state_d = S_DONE;
      S_DONE:     state_d = accept ? entry_state : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from the state register and the latched command.
  always_comb begin
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    Mdatain  = '0;
    op       = (state_q == S_IDLE) ? '0 : op_q;
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = (state_q == S_DONE);
    err      = err_q;
    case (state_q)
      S_MDR_LOAD: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        Mdatain = imm_q;
      end
      S_REG_LOAD: begin
        MDRout = 1'b1;
        Rin    = onehot(src_a_q);
      end
      S_Y_LOAD: begin
        Rout = onehot(src_a_q);
        Yin  = 1'b1;
      end
      S_ALU: begin
        Rout    = onehot(unary_q ? src_a_q : src_b_q);
        Zlowin  = 1'b1;
        Zhighin = wide_q;
      end
      S_ZLO_WB: begin
        Zlowout = 1'b1;
        if (wide_q) LOin = 1'b1;
        else        Rin  = onehot(dst_q);
      end
      S_ZHI_WB: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Self-checking bench for alu_op_sequencer, built with NUM_REGS = 8 so that
// out-of-range indices exist. A reference model turns each command into the
// list of output snapshots it must produce, one per cycle after acceptance;
// every falling edge compares the DUT against the next snapshot (or against
// the all-zero IDLE snapshot when nothing is pending).
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int NR = 8;
  localparam int IW = 4;
  localparam int OW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [IW-1:0] src_a;
    logic [IW-1:0] src_b;
    logic [IW-1:0] dst;
    logic          imm_en;
    logic          unary;
    logic          wide;
    logic [DW-1:0] imm;
  } cmd_t;

  typedef struct packed {
    logic          rd;
    logic          mdr_in;
    logic          mdr_out;
    logic          y_in;
    logic          zlo_in;
    logic          zhi_in;
    logic          zlo_out;
    logic          zhi_out;
    logic          hi_in;
    logic          lo_in;
    logic [NR-1:0] rin;
    logic [NR-1:0] rout;
    logic [OW-1:0] op;
    logic [DW-1:0] mdata;
    logic          busy;
    logic          done;
    logic          err;
  } outs_t;

  typedef struct {
    string name;
    cmd_t  cmd;
    int    exp_lat;   // accept edge to done cycle, inclusive
    logic  exp_err;
  } vec_t;

  logic          Clock = 1'b0;
  logic          clear;
  logic          start;
  logic [OW-1:0] cmd_op;
  logic [IW-1:0] cmd_src_a, cmd_src_b, cmd_dst;
  logic          cmd_imm_en, cmd_unary, cmd_wide;
  logic [DW-1:0] cmd_imm;
  logic          Read, MDRin, MDRout, Yin, Zlowin, Zhighin;
  logic          Zlowout, Zhighout, HIin, LOin;
  logic [NR-1:0] Rin, Rout;
  logic [OW-1:0] op;
  logic [DW-1:0] Mdatain;
  logic          busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  outs_t exp_q[$];

  always #5 Clock = ~Clock;

  alu_op_sequencer #(
    .NUM_REGS (NR),
    .IDX_W    (IW),
    .OP_W     (OW),
    .DATA_W   (DW)
  ) dut (
    .Clock      (Clock),
    .clear      (clear),
    .start      (start),
    .cmd_op     (cmd_op),
    .cmd_src_a  (cmd_src_a),
    .cmd_src_b  (cmd_src_b),
    .cmd_dst    (cmd_dst),
    .cmd_imm_en (cmd_imm_en),
    .cmd_unary  (cmd_unary),
    .cmd_wide   (cmd_wide),
    .cmd_imm    (cmd_imm),
    .Read       (Read),
    .MDRin      (MDRin),
    .MDRout     (MDRout),
    .Yin        (Yin),
    .Zlowin     (Zlowin),
    .Zhighin    (Zhighin),
    .Zlowout    (Zlowout),
    .Zhighout   (Zhighout),
    .HIin       (HIin),
    .LOin       (LOin),
    .Rin        (Rin),
    .Rout       (Rout),
    .op         (op),
    .Mdatain    (Mdatain),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  function automatic outs_t snap();
    outs_t s;
    s.rd      = Read;
    s.mdr_in  = MDRin;
    s.mdr_out = MDRout;
    s.y_in    = Yin;
    s.zlo_in  = Zlowin;
    s.zhi_in  = Zhighin;
    s.zlo_out = Zlowout;
    s.zhi_out = Zhighout;
    s.hi_in   = HIin;
    s.lo_in   = LOin;
    s.rin     = Rin;
    s.rout    = Rout;
    s.op      = op;
    s.mdata   = Mdatain;
    s.busy    = busy;
    s.done    = done;
    s.err     = err;
    return s;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the per-cycle outputs a command must produce, written
  // straight from the operation rules as an ordered list of steps.
  task automatic push_expected(input cmd_t c);
    outs_t         base, s;
    logic [NR-1:0] a1, b1, d1;
    logic          valid;
    valid = (c.src_a < NR) && (c.unary || c.src_b < NR) && (c.wide || c.dst < NR);
    if (!valid) begin
      s = '0;
      s.err = 1'b1;
      exp_q.push_back(s);
      return;
    end
    a1 = NR'(1) << c.src_a;
    b1 = NR'(1) << c.src_b;
    d1 = NR'(1) << c.dst;
    base = '0;
    base.op   = c.op;
    base.busy = 1'b1;
    if (c.imm_en) begin
      s = base; s.rd = 1'b1; s.mdr_in = 1'b1; s.mdata = c.imm;
      exp_q.push_back(s);
      s = base; s.mdr_out = 1'b1; s.rin = a1;
      exp_q.push_back(s);
    end
    if (!c.unary) begin
      s = base; s.y_in = 1'b1; s.rout = a1;
      exp_q.push_back(s);
    end
    s = base; s.rout = c.unary ? a1 : b1; s.zlo_in = 1'b1; s.zhi_in = c.wide;
    exp_q.push_back(s);
    s = base; s.zlo_out = 1'b1;
    if (c.wide) s.lo_in = 1'b1;
    else        s.rin   = d1;
    exp_q.push_back(s);
    if (c.wide) begin
      s = base; s.zhi_out = 1'b1; s.hi_in = 1'b1;
      exp_q.push_back(s);
    end
    s = '0; s.op = c.op; s.done = 1'b1;
    exp_q.push_back(s);
  endtask

  // One cycle: wait for the falling edge, compare against the model.
  task automatic tick();
    outs_t e;
    @(negedge Clock);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : outs_t'('0);
    check("cycle", snap(), e);
    n_cmp++;
    if (!($onehot0(Rin) && $onehot0(Rout))) begin
      n_bad++;
      $display("FAIL onehot @%0t: got Rin=%b Rout=%b required at most one hot", $time, Rin, Rout);
    end
  endtask

  task automatic drive_cmd(input cmd_t c);
    cmd_op     = c.op;
    cmd_src_a  = c.src_a;
    cmd_src_b  = c.src_b;
    cmd_dst    = c.dst;
    cmd_imm_en = c.imm_en;
    cmd_unary  = c.unary;
    cmd_wide   = c.wide;
    cmd_imm    = c.imm;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op     = OW'($urandom);
    c.src_a  = IW'($urandom_range(0, 9));
    c.src_b  = IW'($urandom_range(0, 9));
    c.dst    = IW'($urandom_range(0, 9));
    c.imm_en = 1'($urandom);
    c.unary  = 1'($urandom);
    c.wide   = 1'($urandom);
    c.imm    = $urandom;
    return c;
  endfunction

  // Present a command with start high, take the accepting edge, then drop
  // start and scramble the command inputs to prove they were latched.
  task automatic issue(input cmd_t c);
    drive_cmd(c);
    start = 1'b1;
    push_expected(c);
    tick();
    start = 1'b0;
    drive_cmd(rand_cmd());
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 30) begin
      tick();
      guard++;
    end
    check_int("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic cmd_t mk(input logic [OW-1:0] o, input int a, input int b, input int d,
                              input logic ie, input logic un, input logic wd,
                              input logic [DW-1:0] im);
    cmd_t c;
    c.op = o; c.src_a = IW'(a); c.src_b = IW'(b); c.dst = IW'(d);
    c.imm_en = ie; c.unary = un; c.wide = wd; c.imm = im;
    return c;
  endfunction

  vec_t vecs[10];

  initial begin
    int   n;
    logic got_err;
    cmd_t c;

    vecs[0] = '{"unary_not_imm",  mk(5'b01001, 7, 0, 1, 1, 1, 0, 32'd12),        5, 1'b0};
    vecs[1] = '{"binary_basic",   mk(5'b00011, 2, 3, 4, 0, 0, 0, 32'd0),         4, 1'b0};
    vecs[2] = '{"wide_binary",    mk(5'b00110, 5, 6, 0, 0, 0, 1, 32'd0),         5, 1'b0};
    vecs[3] = '{"reject_dst9",    mk(5'b00110, 5, 6, 9, 0, 0, 0, 32'd0),         0, 1'b1};
    vecs[4] = '{"dst9_wide_ok",   mk(5'b00110, 5, 6, 9, 0, 0, 1, 32'd0),         5, 1'b0};
    vecs[5] = '{"imm_bin_wide",   mk(5'b11111, 0, 7, 3, 1, 0, 1, 32'hffffffff),  7, 1'b0};
    vecs[6] = '{"unary_wide",     mk(5'b10000, 3, 0, 0, 0, 1, 1, 32'd0),         4, 1'b0};
    vecs[7] = '{"reject_src_a8",  mk(5'b00001, 8, 0, 0, 0, 1, 0, 32'd0),         0, 1'b1};
    vecs[8] = '{"unary_b_unused", mk(5'b00101, 6, 15, 2, 0, 1, 0, 32'd0),        3, 1'b0};
    vecs[9] = '{"dst_eq_src",     mk(5'b01010, 4, 4, 4, 0, 0, 0, 32'd0),         4, 1'b0};

    clear = 1'b0;
    start = 1'b0;
    drive_cmd('0);
    repeat (3) tick();               // reset state: all outputs zero
    clear = 1'b1;
    repeat (2) tick();

    // Table-driven directed vectors, each from IDLE.
    foreach (vecs[i]) begin
      issue(vecs[i].cmd);
      got_err = err;
      check_int({vecs[i].name, "_err"}, int'(got_err), int'(vecs[i].exp_err));
      if (!vecs[i].exp_err) begin
        n = 1;
        while (!done && n < 20) begin
          tick();
          n++;
        end
        check_int({vecs[i].name, "_latency"}, n, vecs[i].exp_lat);
      end
      drain();
      tick();
    end

    // start pulsed during ALU is ignored; a start in DONE runs with no bubble.
    c = mk(5'b00011, 2, 3, 4, 0, 0, 0, 32'd0);
    issue(c);                        // Y_LOAD checked
    tick();                          // ALU checked
    drive_cmd(mk(5'b11100, 1, 1, 1, 1, 1, 1, 32'hdead));
    start = 1'b1;                    // sampled while in ALU
    tick();                          // ZLO_WB of the original command
    start = 1'b0;
    drain();                         // through DONE
    issue(mk(5'b00111, 1, 0, 6, 1, 1, 0, 32'h55));
    drain();
    tick();

    // clear low in Y_LOAD: outputs drop at once, no done, no resume.
    issue(mk(5'b00010, 1, 2, 3, 0, 0, 0, 32'd0));
    clear = 1'b0;
    #1;
    check("clear_async", snap(), outs_t'('0));
    exp_q.delete();
    tick();
    clear = 1'b1;
    repeat (6) tick();

    // Randomized commands with random gaps, ignored starts and back-to-back.
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      issue(rand_cmd());
      n = 0;
      while (exp_q.size() > 0 && n < 30) begin
        start = (exp_q.size() > 0) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
        tick();
        n++;
      end
      start = 1'b0;
      check_int("rand_timeout", exp_q.size(), 0);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised micro-sequencer that runs one complete register-transfer ALU operation on `data_path` per command. It drives the one-hot register strobes, MDR/Y/Z/HI/LO strobes, `Read`, `Mdatain` and `op` itself, so a stand-alone bench no longer hand-sequences them. It supports an optional immediate preload, unary or binary operands, and 64-bit (HI/LO) writeback. It sits between a command source (bench or future control unit) and `data_path`.

## Interface
- `NUM_REGS`, 16, number of general registers; width of the `Rin`/`Rout` vectors
- `IDX_W`, 4, register index width; must satisfy 2^IDX_W >= NUM_REGS
- `OP_W`, 5, ALU opcode width
- `DATA_W`, 32, immediate / `Mdatain` width
- `Clock`  in  1  single clock; all state changes on the rising edge
- `clear`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe; sampled in IDLE or DONE
- `cmd_op`  in  OP_W  ALU opcode
- `cmd_src_a`, `cmd_src_b`, `cmd_dst`  in  IDX_W each  register indices
- `cmd_imm_en`  in  1  preload `cmd_imm` into `cmd_src_a` first
- `cmd_unary`  in  1  single operand (`cmd_src_a`); skip Y load
- `cmd_wide`  in  1  write Zlow->LO and Zhigh->HI instead of `cmd_dst`
- `cmd_imm`  in  DATA_W  immediate value
- `Read`, `MDRin`, `MDRout`, `Yin`, `Zlowin`, `Zhighin`, `Zlowout`, `Zhighout`, `HIin`, `LOin`  out  1 each  datapath strobes
- `Rin`, `Rout`  out  NUM_REGS  one-hot register strobes
- `op`  out  OP_W  ALU opcode to the datapath
- `Mdatain`  out  DATA_W  memory-data input to the datapath
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  one-cycle pulse in the DONE state
- `err`  out  1  one-cycle pulse when a command is rejected

## Operation
- Moore FSM. States: IDLE, MDR_LOAD, REG_LOAD, Y_LOAD, ALU, ZLO_WB, ZHI_WB, DONE.
- On accept, all `cmd_*` inputs are latched. Later changes to the inputs have no effect.
- Accept path from IDLE or DONE:
  - `cmd_imm_en` set: go to MDR_LOAD.
  - Otherwise, binary command: go to Y_LOAD.
  - Otherwise, unary command: go to ALU.
- Transitions:
  - MDR_LOAD -> REG_LOAD.
  - REG_LOAD -> Y_LOAD if binary, else ALU.
  - Y_LOAD -> ALU.
  - ALU -> ZLO_WB.
  - ZLO_WB -> ZHI_WB if wide, else DONE.
  - ZHI_WB -> DONE.
  - DONE -> IDLE, or to the accept path if `start` is high.
- Strobes asserted in each state; all others are 0:
  - MDR_LOAD: `Read`, `MDRin`; `Mdatain` = latched imm.
  - REG_LOAD: `MDRout`, `Rin[src_a]`.
  - Y_LOAD: `Rout[src_a]`, `Yin`.
  - ALU: `Rout[src_b]` (binary) or `Rout[src_a]` (unary), `Zlowin`, plus `Zhighin` if wide.
  - ZLO_WB: `Zlowout`, plus `Rin[dst]` (normal) or `LOin` (wide).
  - ZHI_WB: `Zhighout`, `HIin`.
- `op` = latched opcode from the first post-accept state through DONE; 0 in IDLE.
- `Mdatain` = 0 outside MDR_LOAD.
- Rejection: if any used index is >= NUM_REGS, the command is rejected. Used indices are `src_a`, `src_b` if binary, and `dst` if not wide. On rejection: `err` pulses, the FSM stays in or returns to IDLE, and no strobe fires.
- `start` while busy is ignored; there is no queueing.
- `dst` equal to a source index is legal; the writeback occurs last.

## Timing
- Outputs decode from the state register only; each strobe is high for exactly one full cycle.
- Reset values: all outputs 0, state IDLE. `clear` low mid-command aborts immediately with no further strobes. The command is not resumed after `clear` rises.
- Latency from the accepting edge to the `done` cycle (inclusive count of states):
  - Binary: 4 cycles.
  - Unary: 3 cycles.
  - Add 2 cycles for `imm_en`.
  - Add 1 cycle for `wide`.
- Back-to-back: `start` high in DONE begins the next command on the following edge with no IDLE bubble.
- `err` is asserted in the cycle after the rejecting edge.

## Test plan
- Unary NOT with preload: imm_en=1, imm=12, src_a=7, dst=1, unary=1, op=01001 -> MDR_LOAD(`Mdatain`=12), REG_LOAD(`Rin[7]`), ALU(`Rout[7]`, `Zlowin`), ZLO_WB(`Zlowout`, `Rin[1]`), then `done` 5 cycles after accept; `op`=01001 throughout.
- Binary: src_a=2, src_b=3, dst=4, op=00011 -> Y_LOAD(`Rout[2]`, `Yin`), ALU(`Rout[3]`, `Zlowin`), ZLO_WB(`Rin[4]`), `done` after 4 cycles; `Rin`/`Rout` are never multi-hot.
- Wide: src_a=5, src_b=6, wide=1 -> ALU asserts `Zlowin` and `Zhighin`, ZLO_WB asserts `LOin`, ZHI_WB asserts `HIin`, `Rin` stays all-zero, `done` after 5 cycles.
- Handshake: `start` pulsed during ALU is ignored, and the original command completes unchanged. A second `start` in DONE runs immediately with no IDLE cycle.
- Reset: `clear` low during Y_LOAD -> all outputs 0 within the same cycle, state IDLE, no `done`.
- Rejection: with NUM_REGS=8, dst=9 and wide=0 -> `err` pulse, no strobes, `busy` stays 0. The same command with wide=1 is accepted.
